// File: rtl/apb_requester.sv
// APB4 requester: turns single valid/ready commands into one SETUP/ACCESS transfer
// each, and returns read data and error status on a backpressured response port.
module apb_requester #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    sys_clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic                    cmd_write,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_strb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    rsp_timeout,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic                    pwrite,
  output logic                    psel,
  output logic                    penable,
  output logic [DATA_WIDTH/8-1:0] pstrb,
  output logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH-1:0]   prdata,
  input  logic                    pready,
  input  logic                    pslverr
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int CNT_WIDTH  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_LIMIT = CNT_WIDTH'(TIMEOUT_CYCLES);
  localparam bit TIMEOUT_ENABLED = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t               state;
  logic [CNT_WIDTH-1:0] wait_cnt;

  // The APB outputs double as the captured command, so nothing else needs storing.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      cmd_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      paddr       <= '0;
      pwrite      <= 1'b0;
      psel        <= 1'b0;
      penable     <= 1'b0;
      pstrb       <= '0;
      pwdata      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            state     <= SETUP;
            cmd_ready <= 1'b0;
            wait_cnt  <= '0;
            psel      <= 1'b1;
            penable   <= 1'b0;
            paddr     <= cmd_addr;
            pwrite    <= cmd_write;
            pwdata    <= cmd_write ? cmd_wdata : '0;
            pstrb     <= cmd_write ? cmd_strb : {STRB_WIDTH{1'b0}};
          end
        end
        SETUP: begin
          state   <= ACCESS;
          penable <= 1'b1;
        end
        ACCESS: begin
          // A responder that answers on the limit edge still completes normally.
          if (pready) begin
            state       <= RESP;
            psel        <= 1'b0;
            penable     <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_rdata   <= pwrite ? '0 : prdata;
            rsp_err     <= pslverr;
            rsp_timeout <= 1'b0;
          end else if (TIMEOUT_ENABLED && (wait_cnt == TIMEOUT_LIMIT)) begin
            state       <= RESP;
            psel        <= 1'b0;
            penable     <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CNT_WIDTH'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
          psel      <= 1'b0;
          penable   <= 1'b0;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_requester.sv
// Self-checking bench for apb_requester: directed scenarios plus randomized transfers,
// checked against a transaction-level model of the expected response and timing.
module tb_apb_requester;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 4;

  logic          sys_clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic          cmd_write = 1'b0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [SW-1:0] cmd_strb = '0;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] prdata = '0;
  logic          pready = 1'b0;
  logic          pslverr = 1'b0;

  logic          cmd_ready, rsp_valid, rsp_err, rsp_timeout;
  logic [DW-1:0] rsp_rdata, pwdata;
  logic [AW-1:0] paddr;
  logic          pwrite, psel, penable;
  logic [SW-1:0] pstrb;

  logic          nt_cmd_ready, nt_rsp_valid, nt_rsp_err, nt_rsp_timeout;
  logic [DW-1:0] nt_rsp_rdata, nt_pwdata;
  logic [AW-1:0] nt_paddr;
  logic          nt_pwrite, nt_psel, nt_penable;
  logic [SW-1:0] nt_pstrb;

  int compared = 0;
  int mismatched = 0;

  logic [AW-1:0] nxt_addr;
  logic          nxt_write;
  logic [DW-1:0] nxt_wdata;
  logic [SW-1:0] nxt_strb;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    logic          timeout;
    int            access_cycles;
  } rsp_t;

  apb_requester #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .sys_clk(sys_clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_write(cmd_write), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .paddr(paddr), .pwrite(pwrite), .psel(psel), .penable(penable),
    .pstrb(pstrb), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .pslverr(pslverr)
  );

  // Second instance with the timeout disabled, sharing all inputs.
  apb_requester #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(0)) dut_nt (
    .sys_clk(sys_clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(nt_cmd_ready), .cmd_addr(cmd_addr),
    .cmd_write(cmd_write), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(nt_rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(nt_rsp_rdata),
    .rsp_err(nt_rsp_err), .rsp_timeout(nt_rsp_timeout),
    .paddr(nt_paddr), .pwrite(nt_pwrite), .psel(nt_psel), .penable(nt_penable),
    .pstrb(nt_pstrb), .pwdata(nt_pwdata), .prdata(prdata), .pready(pready),
    .pslverr(pslverr)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog expired");
  end

  // Transaction-level expectation: waits beyond the limit abort, otherwise the
  // responder's answer is returned after waits+1 ACCESS cycles.
  function automatic rsp_t model(input logic write, input logic [DW-1:0] prd,
                                 input int waits, input logic slverr);
    rsp_t r;
    r.timeout       = (TO != 0) && (waits > TO);
    r.err           = r.timeout | slverr;
    r.rdata         = (r.timeout || write) ? '0 : prd;
    r.access_cycles = r.timeout ? TO + 1 : waits + 1;
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                             input logic [DW-1:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic checkApbHeld(input string tag, input logic [AW-1:0] a, input logic w,
                              input logic [DW-1:0] wd, input logic [SW-1:0] st);
    checkOutput({tag, " paddr"}, DW'(paddr), DW'(a));
    checkOutput({tag, " pwrite"}, DW'(pwrite), DW'(w));
    checkOutput({tag, " pwdata"}, pwdata, w ? wd : '0);
    checkOutput({tag, " pstrb"}, DW'(pstrb), w ? DW'(st) : '0);
    checkOutput({tag, " cmd_ready"}, DW'(cmd_ready), 0);
    checkOutput({tag, " rsp_valid"}, DW'(rsp_valid), 0);
  endtask

  task automatic applyReset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("reset cmd_ready", DW'(cmd_ready), 1);
    checkOutput("reset psel", DW'(psel), 0);
    checkOutput("reset penable", DW'(penable), 0);
    checkOutput("reset rsp_valid", DW'(rsp_valid), 0);
    checkOutput("reset rsp_rdata", rsp_rdata, 0);
    checkOutput("reset rsp_err", DW'({rsp_err, rsp_timeout}), 0);
    checkOutput("reset paddr", DW'(paddr), 0);
    checkOutput("reset pwdata", pwdata, 0);
  endtask

  // Runs one command end to end, checking the APB phases cycle by cycle and the
  // response against the model; optionally holds the next command during backpressure.
  task automatic applyStimulus(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] wd,
                               input logic [SW-1:0] st, input int waits, input logic slverr,
                               input logic [DW-1:0] prd, input int rsp_delay, input bit hold_next);
    rsp_t exp;
    exp = model(w, prd, waits, slverr);
    checkOutput("idle cmd_ready", DW'(cmd_ready), 1);
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_write = w;
    cmd_wdata = wd;
    cmd_strb  = st;
    pready    = 1'b0;
    tick();
    cmd_valid = 1'b0;
    cmd_wdata = $urandom;
    checkOutput("setup psel", DW'(psel), 1);
    checkOutput("setup penable", DW'(penable), 0);
    checkApbHeld("setup", a, w, wd, st);
    tick();
    checkOutput("access penable", DW'(penable), 1);
    for (int k = 0; k < exp.access_cycles; k++) begin
      pready  = (k == waits);
      prdata  = (k == waits) ? prd : DW'($urandom);
      pslverr = (k == waits) ? slverr : 1'($urandom);
      tick();
      if (k < exp.access_cycles - 1) begin
        checkOutput("wait psel", DW'(psel), 1);
        checkOutput("wait penable", DW'(penable), 1);
        checkApbHeld("wait", a, w, wd, st);
      end
    end
    pready  = 1'b0;
    pslverr = 1'b0;
    checkOutput("done psel", DW'(psel), 0);
    checkOutput("done penable", DW'(penable), 0);
    checkOutput("rsp_valid", DW'(rsp_valid), 1);
    checkOutput("rsp_rdata", rsp_rdata, exp.rdata);
    checkOutput("rsp_err", DW'(rsp_err), DW'(exp.err));
    checkOutput("rsp_timeout", DW'(rsp_timeout), DW'(exp.timeout));
    if (hold_next) begin
      cmd_valid = 1'b1;
      cmd_addr  = nxt_addr;
      cmd_write = nxt_write;
      cmd_wdata = nxt_wdata;
      cmd_strb  = nxt_strb;
    end
    rsp_ready = 1'b0;
    for (int d = 0; d < rsp_delay; d++) begin
      tick();
      checkOutput("bp rsp_valid", DW'(rsp_valid), 1);
      checkOutput("bp rsp_rdata", rsp_rdata, exp.rdata);
      checkOutput("bp rsp_err", DW'({rsp_err, rsp_timeout}), DW'({exp.err, exp.timeout}));
      checkOutput("bp cmd_ready", DW'(cmd_ready), 0);
      checkOutput("bp psel", DW'(psel), 0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checkOutput("hs rsp_valid", DW'(rsp_valid), 0);
    checkOutput("hs cmd_ready", DW'(cmd_ready), 1);
    checkOutput("hs psel", DW'(psel), 0);
  endtask

  initial begin
    $display("[TB] starting apb_requester bench");
    tick();
    applyReset();

    applyStimulus(16'h0000, 1'b1, 32'h12345678, 4'hF, 0, 1'b0, 32'h0BADBEEF, 0, 1'b0);
    applyStimulus(16'h0008, 1'b0, 32'hFFFF0000, 4'hF, 0, 1'b0, 32'h90ABCDEF, 0, 1'b0);
    applyStimulus(16'h0004, 1'b0, 32'h0, 4'h0, 3, 1'b1, 32'h55AA55AA, 0, 1'b0);
    applyStimulus(16'h000C, 1'b0, 32'h0, 4'h0, 100, 1'b0, 32'h77777777, 1, 1'b0);
    applyStimulus(16'h0018, 1'b1, 32'hA5A5A5A5, 4'h3, TO, 1'b0, 32'h0, 0, 1'b0);

    nxt_addr  = 16'h0014;
    nxt_write = 1'b0;
    nxt_wdata = 32'h0;
    nxt_strb  = 4'h0;
    applyStimulus(16'h0010, 1'b1, 32'hDEADBEEF, 4'h5, 1, 1'b0, 32'h0, 5, 1'b1);
    applyStimulus(nxt_addr, nxt_write, nxt_wdata, nxt_strb, 0, 1'b0, 32'h13579BDF, 0, 1'b0);

    $display("[TB] reset during ACCESS");
    cmd_valid = 1'b1;
    cmd_addr  = 16'h0020;
    cmd_write = 1'b0;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    checkOutput("pre-reset penable", DW'(penable), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("midrst psel", DW'(psel), 0);
    checkOutput("midrst penable", DW'(penable), 0);
    checkOutput("midrst rsp_valid", DW'(rsp_valid), 0);
    checkOutput("midrst cmd_ready", DW'(cmd_ready), 1);
    tick();
    checkOutput("post-reset rsp_valid", DW'(rsp_valid), 0);
    applyStimulus(16'h0024, 1'b0, 32'h0, 4'h0, 1, 1'b0, 32'h2468ACE0, 0, 1'b0);

    $display("[TB] randomized transfers");
    for (int n = 0; n < 40; n++) begin
      logic          w;
      logic [AW-1:0] a;
      w = 1'($urandom);
      a = AW'($urandom) & 16'hFFFC;
      applyStimulus(a, w, DW'($urandom), SW'($urandom), int'($urandom_range(0, 6)),
                    1'($urandom), DW'($urandom), int'($urandom_range(0, 3)), 1'b0);
    end

    $display("[TB] timeout disabled instance");
    applyReset();
    checkOutput("nt reset cmd_ready", DW'(nt_cmd_ready), 1);
    cmd_valid = 1'b1;
    cmd_addr  = 16'h0030;
    cmd_write = 1'b0;
    pready    = 1'b0;
    tick();
    cmd_valid = 1'b0;
    checkOutput("nt setup psel", DW'(nt_psel), 1);
    tick();
    for (int c = 0; c < 20; c++) begin
      tick();
      checkOutput("nt wait psel", DW'(nt_psel & nt_penable), 1);
      checkOutput("nt wait rsp_valid", DW'(nt_rsp_valid), 0);
    end
    pready  = 1'b1;
    prdata  = 32'hCAFEF00D;
    pslverr = 1'b0;
    tick();
    pready = 1'b0;
    checkOutput("nt rsp_valid", DW'(nt_rsp_valid), 1);
    checkOutput("nt rsp_rdata", nt_rsp_rdata, 32'hCAFEF00D);
    checkOutput("nt rsp_err", DW'({nt_rsp_err, nt_rsp_timeout}), 0);
    checkOutput("nt done psel", DW'(nt_psel), 0);
    applyReset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/apb_requester.md
Name: apb_requester

Overview:
- APB4 initiator (requester) that drives the register ports of APB responders such as the GPIO controller.
- Accepts single read/write commands on a valid/ready interface and runs one APB setup/access transfer per command.
- Returns read data and error status on a response interface that supports backpressure.
- Bounds responder wait states with a timeout so a hung peripheral cannot stall the bus.

Parameters:
- ADDR_WIDTH, 16, width of paddr and cmd_addr
- DATA_WIDTH, 32, width of data buses; must be a multiple of 8
- TIMEOUT_CYCLES, 255, maximum ACCESS cycles with pready low before abort; 0 disables the timeout

Ports:
- sys_clk  in  1  system clock; all logic is on the rising edge
- rst  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when both cmd_valid and cmd_ready are high
- cmd_addr  in  ADDR_WIDTH  byte address
- cmd_write  in  1  1 = write, 0 = read
- cmd_wdata  in  DATA_WIDTH  write data
- cmd_strb  in  DATA_WIDTH/8  write byte strobes
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed when both rsp_valid and rsp_ready are high
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and for aborted transfers
- rsp_err  out  1  pslverr was sampled, or the transfer timed out
- rsp_timeout  out  1  transfer aborted by timeout
- paddr  out  ADDR_WIDTH  APB address
- pwrite  out  1  APB direction
- psel  out  1  APB select
- penable  out  1  APB enable
- pstrb  out  DATA_WIDTH/8  APB strobes
- pwdata  out  DATA_WIDTH  APB write data
- prdata  in  DATA_WIDTH  APB read data
- pready  in  1  APB ready
- pslverr  in  1  APB slave error

Behaviour:
- Reset, synchronous, checked at sys_clk edge:
  - FSM goes to IDLE and the wait counter clears.
  - All outputs go to 0, except cmd_ready, which is 1 (IDLE).
  - A reset asserted mid-transfer drops psel/penable at that edge.
  - No response is produced for the aborted command.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready=1; psel=0, penable=0.
  - On accept, register addr/write/wdata/strb and go to SETUP.
- SETUP (exactly 1 cycle):
  - psel=1, penable=0; paddr/pwrite from the captured command.
  - pwdata = captured wdata for writes, 0 for reads.
  - pstrb = captured strb for writes, 0 for reads (APB4 rule).
  - Next state: ACCESS.
- ACCESS:
  - psel=1, penable=1; all APB outputs held stable.
  - Edge with pready=1:
    - Capture rsp_rdata (prdata on reads, 0 on writes) and rsp_err=pslverr; set rsp_timeout=0.
    - Drive psel=0, penable=0 and go to RESP.
  - Edge with pready=0: increment the wait counter.
  - Edge with the counter already equal to TIMEOUT_CYCLES (nonzero) and pready=0:
    - Abort: psel=0, penable=0.
    - rsp_rdata=0, rsp_err=1, rsp_timeout=1; go to RESP.
  - pready=1 on the same edge as the timeout limit: pready wins, so the transfer is normal.
  - The counter clears on entry to SETUP.
- RESP:
  - rsp_valid=1; rsp fields held stable until rsp_ready.
  - At the handshake edge: rsp_valid=0, go to IDLE (cmd_ready=1 the following cycle).
  - cmd_ready=0 throughout SETUP, ACCESS and RESP, so there is only ever one outstanding command.
- Timing with zero wait states:
  - Accept at edge N; psel high after N.
  - penable high after N+1.
  - pready sampled at N+2; rsp_valid high after N+2.
  - With rsp_ready tied high, rsp_valid is a 1-cycle pulse; the next accept is possible at N+4.
  - Minimum command period: 4 cycles.
- Each wait state adds one cycle.
- prdata and pslverr are ignored except on the completing ACCESS edge.

Test Plan:
- Write, pready tied 1: cmd addr=0x0, wdata=0x12345678, strb=0xF.
  - paddr=0x0, pwrite=1, pwdata=0x12345678 for 2 cycles.
  - penable high for 1 cycle.
  - rsp_valid high with rsp_err=0, rsp_rdata=0, 3 cycles after accept.
- Read, pready tied 1: addr=0x8, prdata=0x90abcdef.
  - pstrb=0, pwdata=0.
  - rsp_rdata=0x90abcdef, rsp_err=0.
- Wait states and error: read addr=0x4, pready low for 3 ACCESS cycles, then high with pslverr=1.
  - penable high for 4 cycles.
  - APB outputs stable throughout.
  - rsp_err=1, rsp_timeout=0.
- Timeout: TIMEOUT_CYCLES=4, pready held 0.
  - psel drops after 5 ACCESS cycles.
  - rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - Repeat with TIMEOUT_CYCLES=0: transfer waits indefinitely.
- Backpressure: rsp_ready low for 5 cycles after rsp_valid.
  - Response fields stable.
  - cmd_ready=0 while a second cmd_valid is held.
  - Second command accepted the cycle after the rsp handshake.
- Reset mid-transfer: assert rst during ACCESS.
  - psel=0, penable=0, rsp_valid=0, cmd_ready=1 after that edge.
  - A new read then completes normally.
